// File: rtl/fpu_norm_round.sv
// ---------------------------------------------------------------------------
// fpu_norm_round
//   Multicycle normalise / round-to-nearest-even / pack stage that sits after
//   the floating-point mantissa adder. It takes the raw sum (sign, larger
//   biased exponent and an unnormalised mantissa with carry and G/R/S bits).
//   It normalises the sum, rounds it and packs an IEEE-754 word. The start/done
//   handshake is driven by the multicycle controller.
//
//   Build option: FPU_FAST_NORM_EN
//     undefined : the normaliser shifts left one bit per cycle.
//     defined   : a leading-zero count applies the whole left shift in a
//                 single cycle, so start->done latency is always 2.
//     result and flags are bit-identical in both builds.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   start      in   capture inputs (honoured only when busy=0)
//   sign_in    in   result sign
//   exp_in     in   biased exponent of the larger operand
//   man_in     in   [MW-1]=carry, [MW-2]=hidden, [MW-3:3]=frac, [2]=G,
//                   [1]=R, [0]=S   (MW = FRAC_W+5)
//   busy       out  high while the FSM is not idle
//   done       out  one-cycle pulse when result/flags update
//   result     out  packed {sign, exponent, fraction}
//   overflow   out  result rounded to +/-inf
//   underflow  out  nonzero result flushed to zero
//   inexact    out  G|R|S nonzero before rounding, or overflow/underflow
// ---------------------------------------------------------------------------
module fpu_norm_round #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  sign_in,
    input  logic [EXP_W-1:0]      exp_in,
    input  logic [FRAC_W+4:0]     man_in,
    output logic                  busy,
    output logic                  done,
    output logic [EXP_W+FRAC_W:0] result,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  inexact
);

    localparam int MW = FRAC_W + 5;
    localparam int EW = EXP_W + 2;
    localparam int RW = 1 + EXP_W + FRAC_W;

    localparam logic signed [EW-1:0] EXP_ONE = EW'(1);
    localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2
    } state_t;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          ovf;
        logic          unf;
        logic          inx;
    } round_t;

    // Round-to-nearest-even and packing of a normalised mantissa.
    // The carry bit is always clear by the time ROUND is reached, so only
    // the bits from the hidden bit down are passed in.
    function automatic round_t do_round(
        input logic                 s,
        input logic signed [EW-1:0] e,
        input logic [MW-2:0]        m
    );
        round_t                  r;
        logic                    up;
        logic [FRAC_W+1:0]       sum;
        logic [FRAC_W-1:0]       f;
        logic signed [EW-1:0]    e2;
        r = '0;
        if (m == '0) begin
            r = '0;
        end else if (!m[MW-2] || (e < EXP_ONE)) begin
            r.res = {s, {(RW-1){1'b0}}};
            r.unf = 1'b1;
            r.inx = 1'b1;
        end else begin
            up  = m[2] & (m[1] | m[0] | m[3]);
            // {hidden, frac} plus the round increment; a carry out of the
            // hidden bit means the mantissa became exactly 2.0.
            sum = {1'b0, m[MW-2:3]} + {{(FRAC_W+1){1'b0}}, up};
            if (sum[FRAC_W+1]) begin
                f  = sum[FRAC_W:1];
                e2 = e + EXP_ONE;
            end else begin
                f  = sum[FRAC_W-1:0];
                e2 = e;
            end
            if (e2 >= EXP_MAX) begin
                r.res = {s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                r.ovf = 1'b1;
                r.inx = 1'b1;
            end else begin
                r.res = {s, e2[EXP_W-1:0], f};
                r.inx = m[2] | m[1] | m[0];
            end
        end
        return r;
    endfunction

`ifdef FPU_FAST_NORM_EN
    localparam int LZW = $clog2(MW);

    // Leading zeros counted from the hidden-bit position downwards.
    function automatic logic [LZW-1:0] lzc(input logic [MW-2:0] m);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = MW - 2; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      n = n + 1'b1;
            end
        end
        return n;
    endfunction
`endif

    state_t               state_q, state_d;
    logic                 sign_q, sign_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [MW-1:0]        man_q, man_d;
    logic [RW-1:0]        res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 inx_q, inx_d;
    logic                 done_q, done_d;
    round_t               rnd;

`ifdef FPU_FAST_NORM_EN
    logic [LZW-1:0]       lz;
    logic [EW-1:0]        lim;
    logic [EW-1:0]        sh;
`endif

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        man_d   = man_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        inx_d   = inx_q;
        done_d  = 1'b0;
        rnd     = do_round(sign_q, exp_q, man_q[MW-2:0]);
`ifdef FPU_FAST_NORM_EN
        lz  = lzc(man_q[MW-2:0]);
        // Never shift the exponent below 1; leftover zeros become underflow.
        lim = exp_q - EXP_ONE;
        sh  = (EW'(lz) < lim) ? EW'(lz) : lim;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d  = sign_in;
                    exp_d   = signed'({2'b00, exp_in});
                    man_d   = man_in;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (man_q == '0) begin
                    state_d = S_ROUND;
                end else if (man_q[MW-1]) begin
                    // Right shift by one; the dropped bit is folded into sticky.
                    man_d   = {1'b0, man_q[MW-1:2], man_q[1] | man_q[0]};
                    exp_d   = exp_q + EXP_ONE;
                    state_d = S_ROUND;
                end else if (!man_q[MW-2] && (exp_q > EXP_ONE)) begin
`ifdef FPU_FAST_NORM_EN
                    man_d   = man_q << sh;
                    exp_d   = exp_q - signed'(sh);
                    state_d = S_ROUND;
`else
                    man_d   = {man_q[MW-2:0], 1'b0};
                    exp_d   = exp_q - EXP_ONE;
`endif
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                res_d   = rnd.res;
                ovf_d   = rnd.ovf;
                unf_d   = rnd.unf;
                inx_d   = rnd.inx;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and visible outputs: cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            inx_q   <= inx_d;
        end
    end

    // Working operand registers: always reloaded on start before use.
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
        man_q  <= man_d;
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = res_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_fpu_norm_round.sv
module tb_fpu_norm_round;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [27:0] man_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    fpu_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .man_in    (man_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;   // {overflow, underflow, inexact}
        int          due;   // cycle count at which done is expected
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: value-level normalise then round-half-even on integers.
    function automatic void model(input bit s, input int e, input longint m,
                                  output logic [31:0] res, output logic [2:0] flg,
                                  output int lat);
        longint mm;
        longint q;
        int     ee, p, need, allowed, k;
        bit     up;
        mm  = m;
        ee  = e;
        lat = 2;
        res = 32'h0;
        flg = 3'b000;
        if (mm == 0) return;
        if (mm >= (64'd1 << 27)) begin
            mm = (mm >> 1) | (mm & 1);
            ee = ee + 1;
        end else begin
            p = 0;
            for (int i = 0; i < 27; i++) if (((mm >> i) & 1) != 0) p = i;
            need    = 26 - p;
            allowed = (ee > 1) ? ee - 1 : 0;
            k       = (need < allowed) ? need : allowed;
            mm      = mm << k;
            ee      = ee - k;
`ifndef FPU_FAST_NORM_EN
            lat = 2 + k;
`endif
        end
        if (mm < (64'd1 << 26) || ee <= 0) begin
            res = {s, 31'h0};
            flg = 3'b011;
            return;
        end
        q  = mm >> 3;
        up = (((mm >> 2) & 1) != 0) && (((mm & 3) != 0) || ((q & 1) != 0));
        if (up) q = q + 1;
        if (q >= (64'd1 << 24)) begin
            q  = q >> 1;
            ee = ee + 1;
        end
        if (ee >= 255) begin
            res = {s, 8'hFF, 23'h0};
            flg = 3'b101;
            return;
        end
        res = {s, 8'(ee), 23'(q)};
        flg = {2'b00, ((mm & 7) != 0)};
    endfunction

    // Called right after an active edge; start is sampled on the next edge.
    task automatic issue(input bit s, input logic [7:0] e, input logic [27:0] m);
        exp_t x;
        int   lat;
        model(s, int'(e), longint'(m), x.res, x.flg, lat);
        x.due = cyc + 1 + lat;
        sb.push_back(x);
        start   = 1'b1;
        sign_in = s;
        exp_in  = e;
        man_in  = m;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done) got = 1'b1;
        end
        if (!got) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input bit s, input logic [7:0] e, input logic [27:0] m);
        issue(s, e, m);
        wait_done();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("result", 64'(result), 64'(x.res));
                chk("flags", 64'({overflow, underflow, inexact}), 64'(x.flg));
                chk("latency", 64'(cyc), 64'(x.due));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          s;
        logic [7:0]  e;
        logic [27:0] m;
        logic [31:0] r32;
        reset   = 1'b1;
        start   = 1'b0;
        sign_in = 1'b0;
        exp_in  = 8'h0;
        man_in  = 28'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_flags", 64'({overflow, underflow, inexact}), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(1'b0, 8'd127, 28'h8000000);
        run_op(1'b0, 8'd130, 28'h0000008);
        run_op(1'b0, 8'd127, 28'h400000C);
        run_op(1'b0, 8'd127, 28'h4000004);
        run_op(1'b0, 8'd127, 28'h7FFFFFC);
        run_op(1'b0, 8'd254, 28'h8000000);
        run_op(1'b1, 8'd254, 28'h8000000);
        run_op(1'b0, 8'd1,   28'h2000000);
        run_op(1'b1, 8'd5,   28'h0000000);
        run_op(1'b1, 8'd0,   28'h4000000);
        run_op(1'b0, 8'd4,   28'h0000100);

        // start while busy must be ignored
        issue(1'b0, 8'd130, 28'h0000008);
        chk("busy_after_start", 64'(busy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; sign_in = 1'b1; exp_in = 8'd127; man_in = 28'h8000000;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();

        // asynchronous reset in the middle of a long normalisation
        issue(1'b0, 8'd130, 28'h0000008);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        chk("midreset_result", 64'(result), 64'd0);
        chk("midreset_flags", 64'({overflow, underflow, inexact}), 64'd0);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;

        // Randomised operands; each is issued on the done cycle of the previous
        for (int n = 0; n < 250; n++) begin
            s = 1'($urandom);
            case ($urandom_range(0, 7))
                0: e = 8'd0;
                1: e = 8'd1;
                2: e = 8'd2;
                3: e = 8'd253;
                4: e = 8'd254;
                5: e = 8'd255;
                default: e = 8'($urandom_range(1, 254));
            endcase
            r32 = $urandom;
            case ($urandom_range(0, 6))
                0: m = 28'h0;
                1: m = r32[27:0];
                2: m = r32[27:0] >> $urandom_range(1, 27);
                3: m = {2'b01, r32[25:0]};
                4: m = {25'h0FFFFFF, r32[2:0]};
                5: m = {1'b1, r32[26:0]};
                default: m = {2'b01, r32[25:3], 3'b100};
            endcase
            run_op(s, e, m);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
